// File: rtl/fir_mac_sched_if.sv
// Sample-in, result-out and coefficient-write signals of fir_mac_sched.
// The slave modport is the filter side; master is the source/sink side.
interface fir_mac_sched_if #(
    parameter int unsigned TAPS = 8
);
    localparam int unsigned AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic               in_valid;
    logic               in_ready;
    logic signed [12:0] in_data;
    logic               coef_we;
    logic [AW-1:0]      coef_addr;
    logic signed [12:0] coef_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR: one shared external 13x13 multiplier, TAPS MAC cycles per sample.
// Define FIR_SAT_EN to saturate the shifted sum to 16 bits instead of wrapping.
module fir_mac_sched #(
    parameter int unsigned TAPS  = 8,
    parameter int unsigned SHIFT = 12,
    parameter int unsigned ACC_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    fir_mac_sched_if.slave     bus,
    output logic signed [12:0] mul_a,
    output logic signed [12:0] mul_b,
    input  logic signed [25:0] mul_p,
    output logic               busy
);
    localparam int unsigned AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e                   state_q, state_d;
    logic signed [12:0]       x_q [TAPS];
    logic signed [12:0]       c_q [TAPS];
    logic [AW-1:0]            idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [15:0]       out_q;

    logic                     accept;
    logic                     coef_wr;
    logic                     last;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [15:0]       out_sel;

    assign accept  = (state_q == StIdle) && bus.in_valid;
    assign coef_wr = (state_q == StIdle) && bus.coef_we && (32'(bus.coef_addr) < TAPS);
    assign last    = (32'(idx_q) == TAPS - 1);
    assign sum     = acc_q + {{(ACC_W-26){mul_p[25]}}, mul_p};
    assign shifted = sum >>> SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SatMax = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SatMin = ACC_W'(-32768);

    always_comb begin
        out_sel = shifted[15:0];
        if (shifted > SatMax) begin
            out_sel = 16'sh7fff;
        end else if (shifted < SatMin) begin
            out_sel = 16'sh8000;
        end
    end
`else
    assign out_sel = shifted[15:0];
`endif

    assign mul_a         = (state_q == StMac) ? x_q[idx_q] : '0;
    assign mul_b         = (state_q == StMac) ? c_q[idx_q] : '0;
    assign busy          = (state_q != StIdle);
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = out_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StMac;
            StMac:   if (last) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                x_q[0] <= bus.in_data;
                for (int k = 1; k < TAPS; k++) begin
                    x_q[k] <= x_q[k-1];
                end
                acc_q <= '0;
                idx_q <= '0;
            end
            // A write in the accept cycle lands before the first MAC reads c_q.
            if (coef_wr) begin
                c_q[bus.coef_addr] <= bus.coef_data;
            end
            if (state_q == StMac) begin
                acc_q <= sum;
                idx_q <= idx_q + 1'b1;
                if (last) begin
                    out_q <= out_sel;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_mac_sched.sv
// Scoreboard bench: dut0 (TAPS=4, SHIFT=0) and dut1 (TAPS=4, SHIFT=12) with behavioural multipliers.
module tb_fir_mac_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fir_mac_sched_if #(.TAPS(4)) bus0 ();
    fir_mac_sched_if #(.TAPS(4)) bus1 ();

    logic signed [12:0] a0, b0, a1, b1;
    logic signed [25:0] p0, p1;
    logic               busy0, busy1;

    assign p0 = 26'(a0) * 26'(b0);
    assign p1 = 26'(a1) * 26'(b1);

    fir_mac_sched #(.TAPS(4), .SHIFT(0), .ACC_W(32)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .mul_a(a0), .mul_b(b0), .mul_p(p0), .busy(busy0)
    );
    fir_mac_sched #(.TAPS(4), .SHIFT(12), .ACC_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .mul_a(a1), .mul_b(b1), .mul_p(p1), .busy(busy1)
    );

    typedef struct {
        int data;
        int e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 0) ? bus0.in_ready : bus1.in_ready;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int w, input int d, input int exp, input bit push);
        int n = 0;
        if (w == 0) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = 13'(d);
        end else begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = 13'(d);
        end
        while (!rdy(w) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(rdy(w)), 1);
        if (push && rdy(w)) begin
            if (w == 0) q0.push_back('{exp, cyc});
            else        q1.push_back('{exp, cyc});
        end
        @(negedge clk);
        if (w == 0) bus0.in_valid = 1'b0;
        else        bus1.in_valid = 1'b0;
    endtask

    task automatic wr_coef(input int w, input int addr, input int data);
        if (w == 0) begin
            bus0.coef_we = 1'b1; bus0.coef_addr = 2'(addr); bus0.coef_data = 13'(data);
        end else begin
            bus1.coef_we = 1'b1; bus1.coef_addr = 2'(addr); bus1.coef_data = 13'(data);
        end
        @(negedge clk);
        if (w == 0) bus0.coef_we = 1'b0;
        else        bus1.coef_we = 1'b0;
    endtask

    task automatic drain(input int w);
        int n = 0;
        while ((((w == 0) ? q0.size() : q1.size()) != 0 || !rdy(w)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", (w == 0) ? q0.size() : q1.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    bit pend0 = 1'b0, pend1 = 1'b0;
    int rise0 = 0, rise1 = 0;

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (bus0.out_valid && !pend0) begin
            pend0 = 1'b1;
            rise0 = cyc;
        end
        if (bus0.out_valid && bus0.out_ready) begin
            if (q0.size() == 0) begin
                chk("out0_unexpected", 32'(bus0.out_valid), 0);
            end else begin
                e = q0.pop_front();
                chk("out0_data", bus0.out_data, e.data);
                chk("out0_latency", rise0 - e.e, 5);
            end
            pend0 = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (bus1.out_valid && !pend1) begin
            pend1 = 1'b1;
            rise1 = cyc;
        end
        if (bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                chk("out1_unexpected", 32'(bus1.out_valid), 0);
            end else begin
                e = q1.pop_front();
                chk("out1_data", bus1.out_data, e.data);
                chk("out1_latency", rise1 - e.e, 5);
            end
            pend1 = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int sat_exp [4];
        int n;
`ifdef FIR_SAT_EN
        sat_exp = '{32767, 32767, 32767, 32767};
`else
        sat_exp = '{-8191, -16382, -24573, -32764};
`endif
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.coef_we = 1'b0;
        bus0.coef_addr = '0;  bus0.coef_data = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.coef_we = 1'b0;
        bus1.coef_addr = '0;  bus1.coef_data = '0; bus1.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        chk("rst_in_ready", 32'(bus0.in_ready), 1);
        chk("rst_out_valid", 32'(bus0.out_valid), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_busy1", 32'(busy1), 0);
        chk("rst_mul_a", a0, 0);
        chk("rst_mul_b", b0, 0);
        chk("rst_out_data", bus0.out_data, 0);

        // Signed corners through SHIFT=12.
        wr_coef(1, 0, -4096);
        send(1, -4096, 4096, 1'b1);
        send(1, 4095, -4095, 1'b1);
        drain(1);

        // Impulse response.
        for (int k = 0; k < 4; k++) wr_coef(0, k, k + 1);
        send(0, 1, 1, 1'b1);
        send(0, 0, 2, 1'b1);
        send(0, 0, 3, 1'b1);
        send(0, 0, 4, 1'b1);
        send(0, 0, 0, 1'b1);
        drain(0);

        // Coefficient write while busy is dropped; in IDLE it takes effect.
        send(0, 1, 1, 1'b1);
        chk("busy_in_mac", 32'(busy0), 1);
        wr_coef(0, 0, 100);
        send(0, 0, 2, 1'b1);
        drain(0);
        wr_coef(0, 0, 100);
        send(0, 1, 103, 1'b1);
        drain(0);
        bus0.coef_we = 1'b1; bus0.coef_addr = 2'd1; bus0.coef_data = 13'sd7;
        send(0, 0, 11, 1'b1);
        bus0.coef_we = 1'b0;
        drain(0);

        // Backpressure in DONE.
        bus0.out_ready = 1'b0;
        send(0, 2, 203, 1'b1);
        n = 0;
        while (!bus0.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = 13'sd5;
            chk("bp_out_valid", 32'(bus0.out_valid), 1);
            chk("bp_out_data", bus0.out_data, 203);
            chk("bp_in_ready", 32'(bus0.in_ready), 0);
            @(negedge clk);
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(bus0.in_ready), 1);
        chk("bp_release_out_valid", 32'(bus0.out_valid), 0);
        send(0, 0, 18, 1'b1);
        drain(0);

        // Reset mid-MAC at idx=2.
        send(0, 1, 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("mac_mul_a_idx2", a0, 2);
        chk("mac_mul_b_idx2", b0, 3);
        pulse_reset();
        chk("mrst_in_ready", 32'(bus0.in_ready), 1);
        chk("mrst_out_valid", 32'(bus0.out_valid), 0);
        chk("mrst_busy", 32'(busy0), 0);
        chk("mrst_mul_a", a0, 0);
        chk("mrst_mul_b", b0, 0);
        chk("mrst_out_data", bus0.out_data, 0);
        send(0, 1, 0, 1'b1);
        send(0, 0, 0, 1'b1);
        drain(0);
        for (int k = 0; k < 4; k++) wr_coef(0, k, k + 1);
        send(0, 0, 3, 1'b1);
        drain(0);

        // Saturation / wrap of large sums.
        pulse_reset();
        for (int k = 0; k < 4; k++) wr_coef(0, k, 4095);
        for (int k = 0; k < 4; k++) send(0, 4095, sat_exp[k], 1'b1);
        drain(0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_mac_sched.md
# fir_mac_sched

Time-multiplexed FIR scheduler that shares one external signed 13x13 combinational multiplier (26-bit product) across all filter taps. Owns the sample delay line, coefficient register file, tap counter and accumulator. Accepts one sample per valid/ready handshake, runs TAPS multiply-accumulate cycles through the shared multiplier, and presents one scaled output per valid/ready handshake. Sits between the sample source and the output sink of the FIR datapath.

## Interface
- TAPS, 8, number of taps (2..32)
- SHIFT, 12, right shift applied to the accumulator before output selection
- ACC_W, 32, accumulator width (must be at least 26 + clog2(TAPS))
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  sample available
- in_ready  out  1  block can accept a sample
- in_data  in  13  signed sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  tap index
- coef_data  in  13  signed coefficient
- mul_a  out  13  signed multiplier operand A (sample)
- mul_b  out  13  signed multiplier operand B (coefficient)
- mul_p  in  26  signed product from the external multiplier, combinational from mul_a/mul_b
- out_valid  out  1  result available
- out_ready  in  1  sink accepts the result
- out_data  out  16  signed filter output
- busy  out  1  high in MAC or DONE

## Operation
- States: IDLE, MAC, DONE.
- IDLE: in_ready=1. When in_valid=1, shift the delay line (x[0]<=in_data, x[k]<=x[k-1]), clear acc, set idx=0, and go to MAC.
- MAC: mul_a=x[idx], mul_b=c[idx]. acc <= acc + sign_ext(mul_p). idx increments each cycle. On idx==TAPS-1, load out_data from the final sum (acc+product) and go to DONE.
- DONE: out_valid=1, and out_data is held stable. When out_ready=1, go to IDLE.
- Outside MAC, mul_a and mul_b are 0.
- Output selection: take (acc >>> SHIFT) as an arithmetic shift, then keep the low 16 bits (see Configuration).
- Coefficient writes:
  - Accepted only in IDLE: c[coef_addr] <= coef_data.
  - When busy=1, the write is dropped silently.
  - A write and a sample accept in the same IDLE cycle are both performed. The new coefficient applies to that sample's MAC pass.
  - A coef_addr value of TAPS or greater is ignored.
- Reset values:
  - State IDLE, idx=0, acc=0.
  - Every x[k]=0 and every c[k]=0.
  - out_data=0, out_valid=0, busy=0, mul_a=0, mul_b=0.
  - in_ready is 1 in the first cycle after reset.

## Timing
- Accept edge is E (IDLE, in_valid=1). MAC occupies cycles E+1..E+TAPS. out_valid rises at E+TAPS+1.
- Latency from accept to out_valid is TAPS+1 cycles.
- DONE with out_ready=1 at cycle D returns to IDLE at D+1. in_ready rises at D+1.
- Minimum sample period is TAPS+2 cycles when out_ready is held high.
- in_ready is 0 throughout MAC and DONE. in_valid in those states is not consumed.
- out_ready has no effect outside DONE.
- rst=0 in any state, including mid-MAC or in DONE with output pending: everything returns to reset values on the next edge. The partial result is discarded and no out_valid is produced.

## Configuration
- FIR_SAT_EN defined: saturate (acc >>> SHIFT) to the range [-32768, 32767] before taking out_data.
- FIR_SAT_EN undefined: truncate to the low 16 bits, which wraps in two's complement.

## Test plan
- Impulse response, TAPS=4, SHIFT=0, c={1,2,3,4}: samples 1,0,0,0,0 -> out_data 1,2,3,4,0. Each out_valid appears exactly 5 cycles after its accept.
- Signed corners, TAPS=4, SHIFT=12: c[0]=-4096, other coefficients 0, sample -4096 -> product 16777216, out_data=4096. Sample +4095 -> out_data=-4095.
- Saturation, TAPS=4, SHIFT=0: all coefficients and 4 samples equal 4095, so the 4th output's sum is 67076100. Required output: 32767 with FIR_SAT_EN, -32764 without.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Required: out_valid and out_data stable, in_ready=0, and an offered in_valid not consumed. Release out_ready -> in_ready=1 on the next cycle.
- Coefficient write while busy: write c[0]=100 during MAC -> c[0] unchanged, and the next impulse output still equals the old c[0]. The same write in IDLE takes effect.
- Reset mid-MAC: drive rst=0 at idx=2 -> next cycle IDLE, out_valid=0, and all x[k] and c[k] are 0. The following impulse produces all-zero outputs until coefficients are reloaded.
